pad_counter_ctrl: RTL and testbench

- Counter core plus pad-side control that sits directly behind the chip's 45 digital pads.
- Synchronizes the pad-level oeb/web strobes and owns the 41 bidirectional count pads: drives pad_out and per-pad output enables, and loads the count from pad_in.
- Guarantees bus turnaround between chip-driven reads and externally driven writes.
- Instantiated once in the chip top; pad cells connect straight to its pad_* ports.

---
 rtl/pad_counter_pkg.sv | 17 +
 rtl/pad_counter_ctrl_sync_ff.sv | 28 ++
 rtl/pad_counter_ctrl.sv | 143 ++++++++++++++
 tb/tb_pad_counter_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_counter_pkg.sv
// Shared types and constants for the pad-side counter controller.
//   state_e   : bus-direction FSM encoding (RUN, TURN_IN, LOAD, TURN_OUT)
//   WIDTH_DEF : default counter / data-pad width
//   TURN_W    : width of the turnaround down-counter
package pad_counter_pkg;

  localparam int unsigned WIDTH_DEF = 41;
  localparam int unsigned TURN_W    = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    TURN_IN  = 2'd1,
    LOAD     = 2'd2,
    TURN_OUT = 2'd3
  } state_e;

endpackage

// File: rtl/pad_counter_ctrl_sync_ff.sv
// N-flop synchronizer for a single raw pad strobe.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, chain presets to RESET_VAL
//   d_i   : raw asynchronous input
//   q_o   : synchronized output (last stage)
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pad_counter_ctrl.sv
// Counter core plus pad-side bus control behind the chip's digital pads.
// Synchronizes the oeb/web pad strobes, drives the count onto the
// bidirectional pads when allowed, and loads the count from the pads
// during external writes, with idle turnaround cycles on every
// bus-direction change.
//   clk     : core clock
//   rst_n   : asynchronous active-low reset
//   oeb_in  : raw pad, 0 = chip may drive the count pads
//   web_in  : raw pad, 0 = host writes the count through the pads
//   pad_in  : pad input buffers
//   pad_out : pad output data (always the count)
//   pad_oe  : per-pad output enable, 1 = drive
//   count_q : counter value
//   busy    : high while the FSM is not in RUN
// Optional feature macro COUNT_SATURATE_EN: when defined the count holds at
// all-ones in RUN instead of wrapping to zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | counting; pads may be driven when oeb_s low and web_in high
// TURN_IN  | pads released, count held, TURN_CYCLES idle before loading
// LOAD     | count follows pad_in every cycle while web_s low
// TURN_OUT | pads released, count held, TURN_CYCLES idle before RUN
module pad_counter_ctrl
  import pad_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             oeb_in,
  input  logic             web_in,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] count_q,
  output logic             busy
);

  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);

  logic              oeb_s;
  logic              web_s;
  state_e            state_q, state_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [WIDTH-1:0]  count_d;
  logic              busy_q;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_oeb (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (oeb_in),
    .q_o   (oeb_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_web (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (web_in),
    .q_o   (web_s)
  );

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    count_d = count_q;

    case (state_q)
      RUN: begin
        if (!web_s) begin
          state_d = TURN_IN;
          turn_d  = TURN_LOAD;
        end
      end
      TURN_IN: begin
        if (turn_q == '0) begin
          if (!web_s) begin
            state_d = LOAD;
          end else begin
            state_d = TURN_OUT;
            turn_d  = TURN_LOAD;
          end
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      LOAD: begin
        if (web_s) begin
          state_d = TURN_OUT;
          turn_d  = TURN_LOAD;
        end
      end
      TURN_OUT: begin
        // Pads are already released here, so a new write skips TURN_IN.
        if (!web_s) begin
          state_d = LOAD;
        end else if (turn_q == '0) begin
          state_d = RUN;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Count action follows the state being entered, so the edge that
    // leaves a turnaround already loads or increments.
    case (state_d)
      RUN: begin
`ifdef COUNT_SATURATE_EN
        count_d = (&count_q) ? count_q : count_q + 1'b1;
`else
        count_d = count_q + 1'b1;
`endif
      end
      LOAD:    count_d = pad_in;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      turn_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      count_q <= count_d;
      busy_q  <= (state_d != RUN);
    end
  end

  assign busy    = busy_q;
  assign pad_out = count_q;
  // Raw web_in releases the pads in the same cycle the host pulls it low,
  // ahead of the synchronizer, so the two drivers never overlap.
  assign pad_oe  = {WIDTH{(state_q == RUN) & ~oeb_s & web_in}};

endmodule

// File: tb/tb_pad_counter_ctrl.sv
module tb_pad_counter_ctrl;

  localparam int W = 41;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] PVAL = 41'h1_2345_6789A;
  localparam logic [W-1:0] PINC = 41'h1_2345_6789B;
  localparam logic [W-1:0] PPL3 = 41'h1_2345_6789D;
`ifdef COUNT_SATURATE_EN
  localparam logic [W-1:0] WRAP0 = ONES;
  localparam logic [W-1:0] WRAP1 = ONES;
`else
  localparam logic [W-1:0] WRAP0 = '0;
  localparam logic [W-1:0] WRAP1 = 41'd1;
`endif

  localparam int K_CNT  = 0;
  localparam int K_OE   = 1;
  localparam int K_BUSY = 2;
  localparam int K_OUT  = 3;

  logic         clk;
  logic         rst_n;
  logic         oeb_in;
  logic         web_in;
  logic [W-1:0] pad_in;
  logic [W-1:0] pad_out;
  logic [W-1:0] pad_oe;
  logic [W-1:0] count_q;
  logic         busy;

  typedef struct {
    int           due;
    int           kind;
    int           id;
    logic [W-1:0] val;
  } exp_t;

  exp_t         exp_q[$];
  int           edge_n = 0;
  int           n_chk  = 0;
  int           total  = 0;
  int           bad    = 0;
  bit           drain  = 0;
  bit           mon_done = 0;
  logic [W-1:0] mon_act;

  pad_counter_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .TURN_CYCLES(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .oeb_in  (oeb_in),
    .web_in  (web_in),
    .pad_in  (pad_in),
    .pad_out (pad_out),
    .pad_oe  (pad_oe),
    .count_q (count_q),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string kname(input int k);
    case (k)
      K_CNT:   return "count_q";
      K_OE:    return "pad_oe";
      K_BUSY:  return "busy";
      default: return "pad_out";
    endcase
  endfunction

  // Monitor: compares every expectation that has come due, away from the edge.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= edge_n) begin
        case (exp_q[i].kind)
          K_CNT:   mon_act = count_q;
          K_OE:    mon_act = pad_oe;
          K_BUSY:  mon_act = {{(W-1){1'b0}}, busy};
          default: mon_act = pad_out;
        endcase
        total++;
        if (mon_act !== exp_q[i].val) begin
          bad++;
          $display("FAIL chk%0d %s at edge %0d: got %h want %h", exp_q[i].id,
                   kname(exp_q[i].kind), edge_n, mon_act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
    if (drain && !mon_done) begin
      foreach (exp_q[i]) begin
        total++;
        bad++;
        $display("FAIL chk%0d %s never checked: got none want %h", exp_q[i].id,
                 kname(exp_q[i].kind), exp_q[i].val);
      end
      exp_q.delete();
      mon_done = 1;
    end
  end

  // Expect value v on signal kind after k more clock edges.
  task automatic push(input int k, input int kind, input logic [W-1:0] v);
    exp_t e;
    e.due  = edge_n + k;
    e.kind = kind;
    e.id   = n_chk;
    e.val  = v;
    n_chk++;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    oeb_in = 1'b0;
    web_in = 1'b1;
    pad_in = '0;
    @(posedge clk);
    #1;

    // reset and free run
    push(0, K_CNT, '0); push(0, K_OE, '0); push(0, K_BUSY, '0);
    step(4);
    push(0, K_CNT, '0); push(0, K_OE, '0);
    rst_n = 1'b1;
    push(1, K_CNT, 41'd1); push(1, K_OE, '0);
    push(2, K_OE, ONES);   push(2, K_CNT, 41'd2);
    push(10, K_CNT, 41'd10);
    step(20);

    // output enable
    push(0, K_CNT, 41'd20);
    oeb_in = 1'b1;
    push(1, K_OE, ONES); push(2, K_OE, '0);
    push(2, K_CNT, 41'd22); push(3, K_CNT, 41'd23); push(3, K_BUSY, '0);
    step(5);
    oeb_in = 1'b0;
    push(1, K_OE, '0); push(2, K_OE, ONES); push(2, K_CNT, 41'd27);
    step(3);

    // external write
    pad_in = PVAL;
    web_in = 1'b0;
    push(0, K_OE, '0); push(0, K_CNT, 41'd28);
    push(1, K_CNT, 41'd29); push(2, K_CNT, 41'd30); push(2, K_BUSY, '0);
    push(3, K_BUSY, 41'd1); push(3, K_CNT, 41'd30);
    push(4, K_CNT, PVAL); push(4, K_OUT, PVAL); push(4, K_OE, '0);
    step(6);
    web_in = 1'b1;
    push(2, K_OE, '0); push(2, K_CNT, PVAL);
    push(3, K_CNT, PVAL); push(3, K_BUSY, 41'd1); push(3, K_OE, '0);
    push(4, K_CNT, PINC); push(4, K_BUSY, '0); push(4, K_OE, ONES);
    step(6);
    push(0, K_CNT, PPL3);

    // wrap (or saturate) after loading all-ones
    pad_in = ONES;
    web_in = 1'b0;
    push(0, K_OE, '0);
    step(6);
    push(0, K_CNT, ONES); push(0, K_BUSY, 41'd1);
    web_in = 1'b1;
    push(3, K_CNT, ONES); push(4, K_CNT, WRAP0); push(4, K_BUSY, '0);
    push(5, K_CNT, WRAP1);
    step(6);

    // reset while loading
    pad_in = 41'd5;
    web_in = 1'b0;
    step(6);
    push(0, K_CNT, 41'd5); push(0, K_BUSY, 41'd1);
    step(1);
    rst_n = 1'b0;
    push(0, K_CNT, '0); push(0, K_BUSY, '0); push(0, K_OE, '0);
    step(2);
    push(0, K_CNT, '0);
    rst_n = 1'b1;
    push(1, K_CNT, 41'd1); push(2, K_CNT, 41'd2); push(2, K_OE, '0);
    push(3, K_BUSY, 41'd1); push(3, K_CNT, 41'd2);
    push(4, K_CNT, 41'd5); push(4, K_OE, '0);
    step(5);

    // re-write from TURN_OUT; with TURN_CYCLES=1 a one-cycle web pulse
    // lands the FSM in TURN_OUT while web_s is already low again
    web_in = 1'b1;
    pad_in = 41'd7;
    push(1, K_CNT, 41'd7); push(2, K_CNT, 41'd9);
    push(3, K_CNT, 41'd9); push(3, K_BUSY, 41'd1);
    push(4, K_CNT, 41'd11); push(4, K_BUSY, 41'd1); push(5, K_BUSY, 41'd1);
    for (int k = 1; k <= 5; k++) push(k, K_OE, '0);
    step(1);
    web_in = 1'b0;
    pad_in = 41'd9;
    step(2);
    pad_in = 41'd11;
    step(3);

    // resume counting
    web_in = 1'b1;
    push(4, K_CNT, 41'd12); push(4, K_BUSY, '0); push(4, K_OE, ONES);
    step(6);

    drain = 1;
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
